// File: rtl/sha256_msg_schedule_pkg.sv
// Shared SHA-256 definitions for the message-schedule slice: word width,
// round count, schedule FSM states and the round-index type.
package sha256_msg_schedule_pkg;
   localparam int SHA_WORD_W = 32;
   localparam int SHA_ROUNDS = 64;

   typedef enum logic {
      LOAD = 1'b0,
      EMIT = 1'b1
   } state_t;

   typedef logic [5:0]            idx_t;
   typedef logic [SHA_WORD_W-1:0] word_t;
endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Message-word input stream and W-word output stream of the schedule block.
// master = schedule block side, slave = block-assembly / round-core side.
interface sha256_msg_schedule_if;
   import sha256_msg_schedule_pkg::*;

   logic  in_valid;
   logic  in_ready;
   word_t in_word;
   logic  w_valid;
   logic  w_ready;
   word_t w_word;
   idx_t  w_index;

   modport master (
      input  in_valid, in_word, w_ready,
      output in_ready, w_valid, w_word, w_index
   );

   modport slave (
      output in_valid, in_word, w_ready,
      input  in_ready, w_valid, w_word, w_index
   );
endinterface

// File: rtl/sha256_sigma0.sv
// SHA-256 small sigma0: rotr7 ^ rotr18 ^ shr3, purely combinational.
module sha256_sigma0
   import sha256_msg_schedule_pkg::*;
(
   input  word_t i_x,
   output word_t o_y
);
   assign o_y = {i_x[6:0], i_x[31:7]} ^ {i_x[17:0], i_x[31:18]} ^ (i_x >> 3);
endmodule

// File: rtl/sha256_sigma1.sv
// SHA-256 small sigma1: rotr17 ^ rotr19 ^ shr10, purely combinational.
module sha256_sigma1
   import sha256_msg_schedule_pkg::*;
(
   input  word_t i_x,
   output word_t o_y
);
   assign o_y = {i_x[16:0], i_x[31:17]} ^ {i_x[18:0], i_x[31:19]} ^ (i_x >> 10);
endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 message words into a sliding window, then
// streams W[0..ROUNDS-1] while expanding W[t+16] in place behind each emitted word.
module sha256_msg_schedule
   import sha256_msg_schedule_pkg::*;
#(
   parameter int ROUNDS = SHA_ROUNDS,
   parameter int WORD_W = SHA_WORD_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   sha256_msg_schedule_if.master bus,
   output logic                  done
);
   state_t            r_state;
   logic [3:0]        r_lcnt;
   idx_t              r_t;
   logic [WORD_W-1:0] r_win [16];
   logic              r_done;

   word_t             w_s0;
   word_t             w_s1;
   logic [WORD_W-1:0] w_next;
   logic              w_in_hs;
   logic              w_out_hs;

   sha256_sigma0 u_sigma0 (.i_x(r_win[1]),  .o_y(w_s0));
   sha256_sigma1 u_sigma1 (.i_x(r_win[14]), .o_y(w_s1));

   // W[t+16] from the window that currently holds W[t]..W[t+15]
   assign w_next   = w_s1 + r_win[9] + w_s0 + r_win[0];
   assign w_in_hs  = (r_state == LOAD) && bus.in_valid;
   assign w_out_hs = (r_state == EMIT) && bus.w_ready;

   assign bus.in_ready = (r_state == LOAD);
   assign bus.w_valid  = (r_state == EMIT);
   assign bus.w_word   = r_win[0];
   assign bus.w_index  = r_t;
   assign done         = r_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= LOAD;
         r_lcnt  <= '0;
         r_t     <= '0;
         r_done  <= 1'b0;
         for (int i = 0; i < 16; i++) r_win[i] <= '0;
      end else begin
         r_done <= 1'b0;
         // clear outranks both handshakes; the window is left as-is
         if (clear) begin
            r_state <= LOAD;
            r_lcnt  <= '0;
            r_t     <= '0;
         end else if (w_in_hs) begin
            for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
            r_win[15] <= bus.in_word;
            r_lcnt    <= r_lcnt + 4'd1;
            if (r_lcnt == 4'd15) begin
               r_state <= EMIT;
               r_t     <= '0;
            end
         end else if (w_out_hs) begin
            for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
            r_win[15] <= w_next;
            if (r_t == idx_t'(ROUNDS - 1)) begin
               r_state <= LOAD;
               r_t     <= '0;
               r_done  <= 1'b1;
            end else begin
               r_t <= r_t + 6'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Scoreboard bench for sha256_msg_schedule: stimulus pushes expected W words,
// a negedge monitor pops and compares every accepted output word.
module tb_sha256_msg_schedule;
   import sha256_msg_schedule_pkg::*;

   localparam int ROUNDS = 64;

   typedef word_t blk_t [16];
   typedef struct packed {
      logic [5:0]  idx;
      logic [31:0] word;
   } exp_t;

   logic  clk   = 1'b0;
   logic  rst   = 1'b0;
   logic  clear = 1'b0;
   logic  done;
   logic  bp_en = 1'b0;

   exp_t  sb_q [$];
   word_t got_w [64];
   int    n_chk  = 0;
   int    n_fail = 0;

   sha256_msg_schedule_if bus ();

   sha256_msg_schedule #(.ROUNDS(ROUNDS), .WORD_W(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .bus   (bus),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   function automatic word_t rotr(input word_t x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic word_t ss0(input word_t x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic word_t ss1(input word_t x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Reference schedule, textbook recurrence over a flat W array
   task automatic push_block(input blk_t m);
      word_t w [64];
      for (int t = 0; t < 16; t++) w[t] = m[t];
      for (int t = 16; t < 64; t++) w[t] = ss1(w[t-2]) + w[t-7] + ss0(w[t-15]) + w[t-16];
      for (int t = 0; t < ROUNDS; t++) sb_q.push_back('{idx: 6'(t), word: w[t]});
   endtask

   task automatic wait_in_ready();
      int k = 0;
      while (!bus.in_ready && k < 400) begin
         @(posedge clk); #1;
         k++;
      end
      if (!bus.in_ready) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
   endtask

   task automatic feed(input blk_t m, input int n, input bit bubbly);
      for (int i = 0; i < n; i++) begin
         if (bubbly) begin
            int gaps = $urandom_range(0, 2);
            repeat (gaps) begin
               bus.in_valid = 1'b0;
               @(posedge clk); #1;
            end
         end
         bus.in_valid = 1'b1;
         bus.in_word  = m[i];
         wait_in_ready();
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.in_word  = '0;
   endtask

   task automatic drain();
      int k = 0;
      while (sb_q.size() != 0 && k < 3000) begin
         @(posedge clk); #1;
         k++;
      end
      check("drain_queue_empty", 64'(sb_q.size()), 64'd0);
      repeat (3) begin @(posedge clk); #1; end
   endtask

   task automatic wait_index(input logic [5:0] idx);
      int k = 0;
      while (!(bus.w_valid && bus.w_index == idx) && k < 400) begin
         @(posedge clk); #1;
         k++;
      end
      check("wait_index_reached", 64'(bus.w_index), 64'(idx));
   endtask

   // Monitor: scoreboard pops, stall stability, done timing, in_ready during EMIT
   initial begin
      logic prev_stall = 1'b0;
      exp_t prev       = '0;
      exp_t e;
      logic exp_done   = 1'b0;
      int   hs_cnt     = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
            exp_done   = 1'b0;
            hs_cnt     = 0;
            continue;
         end
         check("done_pulse", 64'(done), 64'(exp_done));
         if (done) begin
            check("handshakes_per_block", 64'(hs_cnt), 64'(ROUNDS));
            hs_cnt = 0;
         end
         exp_done = 1'b0;
         if (bus.w_valid) check("in_ready_low_in_emit", 64'(bus.in_ready), 64'd0);
         if (prev_stall && !clear) begin
            check("stall_w_valid", 64'(bus.w_valid), 64'd1);
            check("stall_w_word",  64'(bus.w_word),  64'(prev.word));
            check("stall_w_index", 64'(bus.w_index), 64'(prev.idx));
         end
         if (clear) begin
            prev_stall = 1'b0;
            hs_cnt     = 0;
            continue;
         end
         if (bus.w_valid && bus.w_ready) begin
            if (sb_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_word: got idx %0d word 0x%0h, required no output", bus.w_index, bus.w_word);
            end else begin
               e = sb_q.pop_front();
               check("w_index", 64'(bus.w_index), 64'(e.idx));
               check("w_word",  64'(bus.w_word),  64'(e.word));
            end
            got_w[bus.w_index] = bus.w_word;
            hs_cnt++;
            if (bus.w_index == 6'(ROUNDS - 1)) exp_done = 1'b1;
         end
         prev_stall = bus.w_valid && !bus.w_ready;
         prev       = '{idx: bus.w_index, word: bus.w_word};
      end
   end

   initial begin
      @(posedge clk); #1;
      forever begin
         bus.w_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      blk_t abc, ones, ra, rb, rc, rd;
      bus.in_valid = 1'b0;
      bus.in_word  = '0;
      bus.w_ready  = 1'b1;
      for (int i = 0; i < 16; i++) begin
         abc[i]  = '0;
         ones[i] = 32'hFFFF_FFFF;
         ra[i]   = $urandom;
         rb[i]   = $urandom;
         rc[i]   = $urandom;
         rd[i]   = $urandom;
      end
      abc[0]  = 32'h6162_6380;
      abc[15] = 32'h0000_0018;

      #1 rst = 1'b1;
      #2;
      check("reset_in_ready", 64'(bus.in_ready), 64'd1);
      check("reset_w_valid",  64'(bus.w_valid),  64'd0);
      check("reset_w_index",  64'(bus.w_index),  64'd0);
      check("reset_w_word",   64'(bus.w_word),   64'd0);
      check("reset_done",     64'(done),         64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // "abc" block, consumer always ready
      push_block(abc);
      feed(abc, 16, 1'b0);
      check("first_word_valid_after_load", 64'(bus.w_valid), 64'd1);
      drain();
      check("abc_W0",  64'(got_w[0]),  64'h6162_6380);
      check("abc_W15", 64'(got_w[15]), 64'h0000_0018);
      check("abc_W16", 64'(got_w[16]), 64'h6162_6380);
      check("abc_W17", 64'(got_w[17]), 64'h000F_0000);

      // "abc" block under random backpressure
      bp_en = 1'b1;
      push_block(abc);
      feed(abc, 16, 1'b0);
      drain();
      bp_en = 1'b0;
      check("bp_abc_W17", 64'(got_w[17]), 64'h000F_0000);

      // bubbly input then two back-to-back blocks
      push_block(ra);
      push_block(rb);
      feed(ra, 16, 1'b1);
      feed(rb, 16, 1'b0);
      drain();

      // clear mid-load, with a live input handshake in the clear cycle
      feed(rc, 7, 1'b0);
      clear        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_word  = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      clear        = 1'b0;
      bus.in_valid = 1'b0;
      check("clear_load_in_ready", 64'(bus.in_ready), 64'd1);
      push_block(rd);
      feed(rd, 16, 1'b0);
      drain();

      // clear at t=30: output stops, no done pulse
      push_block(ra);
      feed(ra, 16, 1'b0);
      wait_index(6'd30);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      sb_q.delete();
      check("clear_emit_w_valid",  64'(bus.w_valid),  64'd0);
      check("clear_emit_in_ready", 64'(bus.in_ready), 64'd1);
      repeat (70) begin @(posedge clk); #1; end

      // async reset between edges mid-EMIT
      push_block(rb);
      feed(rb, 16, 1'b0);
      wait_index(6'd20);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_w_valid",  64'(bus.w_valid),  64'd0);
      check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_mid_w_index",  64'(bus.w_index),  64'd0);
      sb_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      push_block(rc);
      feed(rc, 16, 1'b0);
      drain();

      // all-ones block exercises mod-2^32 wrap of the four-term sum
      push_block(ones);
      feed(ones, 16, 1'b0);
      drain();
      check("ones_W16_wrap", 64'(got_w[16]), 64'h203F_FFFC);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
